rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single-address-port program ROM between two requesters: the instruction-fetch stage (IF) and the literal-pool/constant load path of the memory stage (DM). Each cycle it grants at most one requester, drives the ROM word address, and captures the matching ROM output (instruction word for IF, constant word for DM) into a registered response one cycle later. Data requests have priority, and a burst limit guarantees that fetch is never starved.

## Interface
Parameters:
- MAX_DATA_BURST, 4: maximum consecutive DM grants while IF is requesting; legal range 1-15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- Rst_n  in  1  asynchronous, active-low reset
- hold  in  1  debug/single-step freeze; when high, no grants are issued
- if_req  in  1  IF request; held high until granted
- if_addr  in  32  IF byte address
- if_gnt  out  1  IF granted this cycle (combinational)
- if_rvalid  out  1  IF response valid (registered)
- if_rdata  out  32  IF instruction word
- if_err  out  1  IF access error, qualified by if_rvalid
- dm_req  in  1  DM request; held high until granted
- dm_addr  in  32  DM byte address
- dm_gnt  out  1  DM granted this cycle (combinational)
- dm_rvalid  out  1  DM response valid (registered)
- dm_rdata  out  32  DM constant word
- dm_err  out  1  DM access error, qualified by dm_rvalid
- rom_addr  out  8  ROM word address (combinational)
- rom_instr  in  32  ROM instruction output
- rom_data  in  32  ROM constant output

## Operation
- Requesters assert req with a stable address until gnt is high in the same cycle. The transfer completes on the clock edge where req and gnt are both high.
- Grant rule, evaluated when hold is low:
  - DM wins if dm_req is high and burst_cnt < MAX_DATA_BURST.
  - Otherwise IF wins if if_req is high.
  - Otherwise DM wins if dm_req is high (no IF contention).
- hold high forces if_gnt = dm_gnt = 0. Pending requests stay pending, and burst_cnt is frozen.
- burst_cnt is a 4-bit register:
  - On a DM grant while if_req is high: increments, saturating at MAX_DATA_BURST.
  - On an IF grant, or any cycle where if_req is low: cleared to 0.
- rom_addr equals {1'b0, winner_addr[8:2]}. It is 0 when there is no grant.
- Address checks on the granted address:
  - If addr[31:9] != 0 (out of range), rdata is 32'h0 and err = 1.
  - If addr[1:0] != 0 (misaligned), err = 1 and rdata is the word at addr[8:2].
  - Both checks OR into err.
- Response register: on a granted edge, the winner's rvalid is set to 1 for exactly one cycle. rdata latches rom_instr for IF or rom_data for DM. The loser's rvalid is 0.
- rdata holds its last value when rvalid is low.
- Responses have no backpressure. Requesters must accept the response in the cycle rvalid is high.

## Timing
- Reset (Rst_n low, asynchronous): if_rvalid = dm_rvalid = 0, if_rdata = dm_rdata = 0, if_err = dm_err = 0, burst_cnt = 0.
- During reset, gnt and rom_addr are forced to 0.
- Reset asserted mid-transfer discards the in-flight response; the response is not replayed.
- Latency: gnt arrives in the same cycle as req (zero wait when uncontended). rvalid and rdata arrive 1 cycle after the granting edge.
- Throughput: one grant per cycle. Back-to-back grants to the same requester give consecutive rvalid pulses.
- Simultaneous if_req and dm_req: DM is granted for MAX_DATA_BURST consecutive cycles, then IF for 1 cycle, and the pattern repeats.
- hold rising in the same cycle as req: no grant that cycle. The response for the previous cycle's grant still appears normally.
- Wrap-around: byte addresses 0x000-0x1FF map to words 0-127. 0x200 and above is out of range and never aliases onto a ROM word.

## Test plan
- Reset then single IF read: if_req = 1, if_addr = 0x0 → if_gnt = 1 the same cycle, rom_addr = 0, next cycle if_rvalid = 1, if_rdata = 32'hE3A00000, if_err = 0.
- Single DM read: dm_addr = 0x4 → rom_addr = 1, next cycle dm_rvalid = 1, dm_rdata = 32'hABCD1234.
- Contention with MAX_DATA_BURST = 4: if_req and dm_req held high for 10 cycles → grant sequence DM, DM, DM, DM, IF, DM, DM, DM, DM, IF. Each rvalid pulse arrives one cycle after its grant.
- Errors: dm_addr = 0x200 → dm_rdata = 0, dm_err = 1. if_addr = 0x6 → if_err = 1, if_rdata = 32'hE0800001.
- hold: assert hold for 3 cycles with both requests pending → no gnt, burst_cnt unchanged. After release, arbitration resumes from the same count.
- Reset mid-operation: drop Rst_n in the cycle after a DM grant → dm_rvalid = 0 and dm_rdata = 0 immediately. No stale response after Rst_n is released.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-address program ROM port between instruction fetch (IF)
// and the literal-pool load path (DM), with a registered one-cycle response.
module rom_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        hold,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_instr,
  input  logic [31:0] rom_data
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

  logic [3:0]  burst_cnt;
  logic [31:0] win_addr;
  logic        win_oor;
  logic        win_err;

  // DM has priority until it has used up its burst allowance against a waiting fetch.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (Rst_n && !hold) begin
      if (dm_req && ((burst_cnt < MAX_CNT) || !if_req)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    win_addr = dm_gnt ? dm_addr : if_addr;
    win_oor  = |win_addr[31:9];
    win_err  = win_oor | (|win_addr[1:0]);
    rom_addr = (if_gnt || dm_gnt) ? {1'b0, win_addr[8:2]} : 8'd0;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      burst_cnt <= 4'd0;
    end else if (!hold) begin
      if (if_gnt || !if_req) begin
        burst_cnt <= 4'd0;
      end else if (dm_gnt && (burst_cnt < MAX_CNT)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Out-of-range accesses return zero so they never alias onto a real ROM word.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= 32'd0;
      dm_err    <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      dm_rvalid <= dm_gnt;
      if (if_gnt) begin
        if_rdata <= win_oor ? 32'd0 : rom_instr;
        if_err   <= win_err;
      end
      if (dm_gnt) begin
        dm_rdata <= win_oor ? 32'd0 : rom_data;
        dm_err   <= win_err;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed scoreboard bench for rom_port_arbiter with an asynchronous-read ROM model.
module tb_rom_port_arbiter;

  logic        clk;
  logic        Rst_n;
  logic        hold;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] rom_data;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    contention_dm[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  rom_port_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .hold      (hold),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .rom_addr  (rom_addr),
    .rom_instr (rom_instr),
    .rom_data  (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_word(input logic [7:0] w);
    case (w)
      8'd0:    instr_word = 32'hE3A00000;
      8'd1:    instr_word = 32'hE0800001;
      default: instr_word = {16'hC0DE, 8'h00, w};
    endcase
  endfunction

  function automatic logic [31:0] data_word(input logic [7:0] w);
    case (w)
      8'd1:    data_word = 32'hABCD1234;
      default: data_word = {16'hDA7A, 8'h00, w};
    endcase
  endfunction

  assign rom_instr = instr_word(rom_addr);
  assign rom_data  = data_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic resp_t expected_resp(input logic is_dm, input logic [31:0] addr);
    resp_t r;
    logic [7:0] w;
    w       = {1'b0, addr[8:2]};
    r.is_dm = is_dm;
    r.err   = (addr[31:9] != 23'd0) || (addr[1:0] != 2'd0);
    if (addr[31:9] != 23'd0) r.data = 32'd0;
    else                     r.data = is_dm ? data_word(w) : instr_word(w);
    return r;
  endfunction

  task automatic check_output(input string tag);
    resp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_dm) begin
        check({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'd1);
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({tag, ".dm_rdata"}, dm_rdata, e.data);
        check({tag, ".dm_err"}, 32'(dm_err), 32'(e.err));
      end else begin
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd1);
        check({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'd0);
        check({tag, ".if_rdata"}, if_rdata, e.data);
        check({tag, ".if_err"}, 32'(if_err), 32'(e.err));
      end
    end else begin
      check({tag, ".if_rvalid_idle"}, 32'(if_rvalid), 32'd0);
      check({tag, ".dm_rvalid_idle"}, 32'(dm_rvalid), 32'd0);
    end
  endtask

  // Called just after a falling edge with inputs already set; ends on the next falling edge.
  task automatic apply_stimulus(input logic exp_if, input logic exp_dm, input string tag);
    logic [7:0] exp_rom;
    #1;
    check({tag, ".if_gnt"}, 32'(if_gnt), 32'(exp_if));
    check({tag, ".dm_gnt"}, 32'(dm_gnt), 32'(exp_dm));
    if (exp_dm)      exp_rom = {1'b0, dm_addr[8:2]};
    else if (exp_if) exp_rom = {1'b0, if_addr[8:2]};
    else             exp_rom = 8'd0;
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'(exp_rom));
    if (exp_dm)      sb.push_back(expected_resp(1'b1, dm_addr));
    else if (exp_if) sb.push_back(expected_resp(1'b0, if_addr));
    @(posedge clk);
    #1;
    check_output(tag);
    @(negedge clk);
  endtask

  initial begin
    Rst_n   = 1'b0;
    hold    = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0;
    dm_req  = 1'b0;
    dm_addr = 32'h0;
    #1;
    check("rst.if_gnt", 32'(if_gnt), 32'd0);
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check("rst.if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst.dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("rst.if_rdata", if_rdata, 32'd0);
    check("rst.dm_rdata", dm_rdata, 32'd0);
    check("rst.if_err", 32'(if_err), 32'd0);
    check("rst.dm_err", 32'(dm_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b0;
    Rst_n  = 1'b1;
    apply_stimulus(1'b0, 1'b0, "idle0");

    if_req = 1'b1; if_addr = 32'h0;
    apply_stimulus(1'b1, 1'b0, "if_single");
    if_req = 1'b0;
    dm_req = 1'b1; dm_addr = 32'h4;
    apply_stimulus(1'b0, 1'b1, "dm_single");
    dm_req = 1'b0;
    apply_stimulus(1'b0, 1'b0, "idle1");

    // Uncontended DM is never throttled by the burst limit.
    dm_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dm_addr = 32'(i * 4 + 8);
      apply_stimulus(1'b0, 1'b1, $sformatf("dm_only%0d", i));
    end

    if_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(!contention_dm[i], contention_dm[i], $sformatf("contend%0d", i));
    end
    if_req = 1'b0; dm_req = 1'b0;
    apply_stimulus(1'b0, 1'b0, "idle2");

    dm_req = 1'b1; dm_addr = 32'h200;
    apply_stimulus(1'b0, 1'b1, "dm_oor");
    dm_addr = 32'h1FC;
    apply_stimulus(1'b0, 1'b1, "dm_top_word");
    dm_addr = 32'h203;
    apply_stimulus(1'b0, 1'b1, "dm_oor_misal");
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h6;
    apply_stimulus(1'b1, 1'b0, "if_misal");
    if_addr = 32'h1FF;
    apply_stimulus(1'b1, 1'b0, "if_top_misal");
    if_req = 1'b0;
    apply_stimulus(1'b0, 1'b0, "idle3");

    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_addr = 32'h24;
    apply_stimulus(1'b0, 1'b1, "pre_hold0");
    apply_stimulus(1'b0, 1'b1, "pre_hold1");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, $sformatf("hold%0d", i));
    hold = 1'b0;
    apply_stimulus(1'b0, 1'b1, "post_hold0");
    apply_stimulus(1'b0, 1'b1, "post_hold1");
    apply_stimulus(1'b1, 1'b0, "post_hold_if");
    if_req = 1'b0; dm_req = 1'b0;
    apply_stimulus(1'b0, 1'b0, "idle4");

    dm_req = 1'b1; dm_addr = 32'h4;
    #1;
    check("mid_rst.dm_gnt", 32'(dm_gnt), 32'd1);
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    check("mid_rst.dm_rvalid_pre", 32'(dm_rvalid), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst.dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("mid_rst.dm_rdata", dm_rdata, 32'd0);
    check("mid_rst.dm_gnt_rst", 32'(dm_gnt), 32'd0);
    sb.delete();
    @(negedge clk);
    Rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, "after_rst0");
    apply_stimulus(1'b0, 1'b0, "after_rst1");
    check("after_rst.dm_rdata", dm_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
